// File: rtl/led_step_sequencer_if.sv
// Board-side signal bundle for the LED step sequencer: button/config inputs
// toward the sequencer and step/status outputs back toward the board.
interface led_step_sequencer_if;
   logic       btn_run;
   logic       burst_start;
   logic [3:0] burst_len;
   logic [1:0] speed;
   logic       step_en;
   logic       running;
   logic       burst_active;
   logic [7:0] step_count;

   // Board / stimulus side: drives requests and config, observes status.
   modport master (
      output btn_run, burst_start, burst_len, speed,
      input  step_en, running, burst_active, step_count
   );

   // Sequencer side.
   modport slave (
      input  btn_run, burst_start, burst_len, speed,
      output step_en, running, burst_active, step_count
   );
endinterface

// File: rtl/led_step_sequencer.sv
// LED step sequencer: produces fixed-width step pulses for the 4-LED rotator,
// either continuously (toggled by a debounced push-button) or as finite bursts.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no activity, waiting for button toggle or burst request
// S_WAIT  | counting the step interval (1<<speed) * TICK_DIV cycles
// S_PULSE | step_en high for PULSE_LEN cycles
// S_GAP   | step_en low for PULSE_LEN cycles, then decide stop/continue
module led_step_sequencer #(
   parameter int TICK_DIV        = 1200000,
   parameter int PULSE_LEN       = 4,
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input logic                 clk,
   input logic                 reset_n,
   led_step_sequencer_if.slave bus
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PULSE_W = $clog2(PULSE_LEN) + 1;
   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;

   localparam logic [PRESC_W-1:0] PRESC_LOAD = PRESC_W'(TICK_DIV - 1);
   localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(PULSE_LEN - 1);
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_PULSE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t             r_state;
   logic               r_sync1;
   logic               r_sync2;
   logic               r_db_level;
   logic [DB_W-1:0]    r_db_cnt;
   logic               r_toggle;
   logic [PRESC_W-1:0] r_presc;
   logic [2:0]         r_ticks;
   logic [PULSE_W-1:0] r_pulse_cnt;
   logic [3:0]         r_remaining;
   logic               r_stop_pending;
   logic               r_step_en;
   logic               r_running;
   logic               r_burst_active;
   logic [7:0]         r_step_count;

   logic [2:0]         w_ticks_load;
   logic               w_burst_req;
   logic               w_gap_stop;

   // Interval length in base ticks minus one, taken from speed at WAIT entry.
   assign w_ticks_load = 3'((4'd1 << bus.speed) - 4'd1);
   assign w_burst_req  = bus.burst_start && (bus.burst_len != 4'd0);
   // A toggle arriving on the last GAP cycle still counts as a stop.
   assign w_gap_stop   = r_stop_pending || r_toggle ||
                         (r_burst_active && (r_remaining == 4'd0));

   // Button path: two-flop synchroniser, debounce counter, rising-edge toggle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_db_level <= 1'b0;
         r_db_cnt   <= '0;
         r_toggle   <= 1'b0;
      end else begin
         r_sync1  <= bus.btn_run;
         r_sync2  <= r_sync1;
         r_toggle <= 1'b0;
         if (r_sync2 != r_db_level) begin
            if (r_db_cnt == DB_LAST) begin
               r_db_level <= r_sync2;
               r_db_cnt   <= '0;
               r_toggle   <= r_sync2;
            end else begin
               r_db_cnt <= r_db_cnt + DB_W'(1);
            end
         end else begin
            r_db_cnt <= '0;
         end
      end
   end

   // Step sequencing FSM with registered step_en and status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_presc        <= '0;
         r_ticks        <= '0;
         r_pulse_cnt    <= '0;
         r_remaining    <= '0;
         r_stop_pending <= 1'b0;
         r_step_en      <= 1'b0;
         r_running      <= 1'b0;
         r_burst_active <= 1'b0;
         r_step_count   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_step_en      <= 1'b0;
               r_stop_pending <= 1'b0;
               if (r_toggle) begin
                  r_state        <= S_WAIT;
                  r_running      <= 1'b1;
                  r_burst_active <= 1'b0;
                  r_presc        <= PRESC_LOAD;
                  r_ticks        <= w_ticks_load;
               end else if (w_burst_req) begin
                  r_state        <= S_WAIT;
                  r_running      <= 1'b1;
                  r_burst_active <= 1'b1;
                  r_remaining    <= bus.burst_len;
                  r_presc        <= PRESC_LOAD;
                  r_ticks        <= w_ticks_load;
               end
            end

            S_WAIT: begin
               if (r_toggle) begin
                  // Stop during the interval: abandon it, no pulse.
                  r_state        <= S_IDLE;
                  r_running      <= 1'b0;
                  r_burst_active <= 1'b0;
                  r_stop_pending <= 1'b0;
               end else if (r_presc == '0) begin
                  if (r_ticks == 3'd0) begin
                     r_state      <= S_PULSE;
                     r_step_en    <= 1'b1;
                     r_pulse_cnt  <= PULSE_LOAD;
                     r_step_count <= r_step_count + 8'd1;
                     if (r_burst_active) begin
                        r_remaining <= r_remaining - 4'd1;
                     end
                  end else begin
                     r_ticks <= r_ticks - 3'd1;
                     r_presc <= PRESC_LOAD;
                  end
               end else begin
                  r_presc <= r_presc - PRESC_W'(1);
               end
            end

            S_PULSE: begin
               if (r_toggle) begin
                  r_stop_pending <= 1'b1;
               end
               if (r_pulse_cnt == '0) begin
                  r_state     <= S_GAP;
                  r_step_en   <= 1'b0;
                  r_pulse_cnt <= PULSE_LOAD;
               end else begin
                  r_pulse_cnt <= r_pulse_cnt - PULSE_W'(1);
               end
            end

            S_GAP: begin
               if (r_pulse_cnt == '0) begin
                  if (w_gap_stop) begin
                     r_state        <= S_IDLE;
                     r_running      <= 1'b0;
                     r_burst_active <= 1'b0;
                     r_stop_pending <= 1'b0;
                  end else begin
                     r_state <= S_WAIT;
                     r_presc <= PRESC_LOAD;
                     r_ticks <= w_ticks_load;
                  end
               end else begin
                  r_pulse_cnt <= r_pulse_cnt - PULSE_W'(1);
                  if (r_toggle) begin
                     r_stop_pending <= 1'b1;
                  end
               end
            end

            default: begin
               r_state   <= S_IDLE;
               r_step_en <= 1'b0;
               r_running <= 1'b0;
            end
         endcase
      end
   end

   assign bus.step_en      = r_step_en;
   assign bus.running      = r_running;
   assign bus.burst_active = r_burst_active;
   assign bus.step_count   = r_step_count;

endmodule

// File: tb/tb_led_step_sequencer.sv
// Scoreboard bench for led_step_sequencer: stimulus pushes expected step
// pulses (rise cycle, step_count, burst flag); a monitor pops on every
// step_en rising edge and also checks each pulse width.
module tb_led_step_sequencer;

   localparam int TICK_DIV  = 4;
   localparam int PULSE_LEN = 2;
   localparam int DEB       = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   led_step_sequencer_if bus();

   led_step_sequencer #(
      .TICK_DIV        (TICK_DIV),
      .PULSE_LEN       (PULSE_LEN),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         rise;
      logic [7:0] cnt;
      logic       burst;
   } exp_t;

   exp_t       exp_q[$];
   int         n_total = 0;
   int         n_pass  = 0;
   logic [7:0] exp_cnt = 8'd0;

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_pulse(input int rise, input logic burst);
      exp_cnt = exp_cnt + 8'd1;
      exp_q.push_back('{rise, exp_cnt, burst});
   endtask

   // Button press starts a continuous run of w-cycle intervals; a second press
   // timed to land during the n-th pulse stops it after that pulse's GAP.
   task automatic cont_run(input int w, input int n, input bit with_burst);
      int k;
      int r_last;
      k      = cyc + 1;
      r_last = k + 11 + w + (n - 1) * (w + 2 * PULSE_LEN);
      for (int i = 0; i < n; i++) push_pulse(k + 11 + w + i * (w + 2 * PULSE_LEN), 1'b0);
      wait_cyc(k);
      bus.btn_run = 1'b1;
      wait_cyc(k + 10);
      check("idle_before_toggle", int'(bus.running), 0);
      if (with_burst) begin
         bus.burst_len   = 4'd3;
         bus.burst_start = 1'b1;
      end
      wait_cyc(k + 11);
      bus.burst_start = 1'b0;
      check("running_after_toggle", int'(bus.running), 1);
      check("cont_no_burst_flag", int'(bus.burst_active), 0);
      wait_cyc(k + 12);
      bus.btn_run = 1'b0;
      wait_cyc(r_last - 10);
      bus.btn_run = 1'b1;
      wait_cyc(r_last + 2);
      bus.btn_run = 1'b0;
      wait_cyc(r_last + 3);
      check("running_in_final_gap", int'(bus.running), 1);
      wait_cyc(r_last + 4);
      check("idle_after_stop", int'(bus.running), 0);
      check("count_after_run", int'(bus.step_count), int'(exp_cnt));
      wait_cyc(r_last + 20);
   endtask

   task automatic run_burst(input int len, input int w, input bit inject);
      int b;
      int last;
      b    = cyc;
      last = b + 1 + w + (len - 1) * (w + 2 * PULSE_LEN);
      bus.burst_len   = 4'(len);
      bus.burst_start = 1'b1;
      for (int i = 0; i < len; i++) push_pulse(b + 1 + w + i * (w + 2 * PULSE_LEN), 1'b1);
      wait_cyc(b + 1);
      bus.burst_start = 1'b0;
      if (inject) begin
         wait_cyc(b + 10);
         bus.burst_len   = 4'd5;
         bus.burst_start = 1'b1;
         wait_cyc(b + 11);
         bus.burst_start = 1'b0;
      end
      wait_cyc(last + 3);
      check("burst_active_last_gap", int'(bus.burst_active), 1);
      wait_cyc(last + 4);
      check("burst_done_idle", int'(bus.running), 0);
      check("burst_done_flag", int'(bus.burst_active), 0);
   endtask

   // Monitor: pop and compare on each step_en rise; check width on each fall.
   logic prev_en = 1'b0;
   int   width   = 0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_en = 1'b0;
         width   = 0;
      end else begin
         if (bus.step_en && !prev_en) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_pulse: step_en rose at cycle %0d, expected no pulse", cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("pulse_rise_cycle", cyc, e.rise);
               check("pulse_step_count", int'(bus.step_count), int'(e.cnt));
               check("pulse_burst_flag", int'(bus.burst_active), int'(e.burst));
            end
            width = 1;
         end else if (bus.step_en) begin
            width++;
         end else if (prev_en) begin
            check("pulse_width", width, PULSE_LEN);
         end
         prev_en = bus.step_en;
      end
   end

   initial begin
      repeat (30000) @(posedge clk);
      $display("FAIL watchdog: run still active at cycle %0d", cyc);
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int bad;
      int b;
      bus.btn_run     = 1'b0;
      bus.burst_start = 1'b0;
      bus.burst_len   = 4'd0;
      bus.speed       = 2'd0;
      reset_n         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_step_en", int'(bus.step_en), 0);
      check("reset_running", int'(bus.running), 0);
      check("reset_burst_active", int'(bus.burst_active), 0);
      check("reset_step_count", int'(bus.step_count), 0);
      reset_n = 1'b1;

      bad = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (bus.step_en || bus.running || bus.step_count != 8'd0) bad++;
      end
      check("reset_quiet_cycles", bad, 0);

      for (int i = 0; i < 10; i++) begin
         bus.btn_run = (i % 2 == 0) ? 1'b1 : 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end
      bus.btn_run = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("bounce_ignored", int'(bus.running), 0);

      bus.speed = 2'd0;
      cont_run(4, 4, 1'b0);

      bus.speed = 2'd1;
      cont_run(8, 6, 1'b0);

      bus.speed = 2'd0;
      run_burst(3, 4, 1'b1);

      bus.burst_len   = 4'd0;
      bus.burst_start = 1'b1;
      @(posedge clk);
      #1;
      bus.burst_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("len0_ignored", int'(bus.running), 0);

      cont_run(4, 4, 1'b1);

      b = cyc;
      bus.burst_len   = 4'd3;
      bus.burst_start = 1'b1;
      wait_cyc(b + 1);
      bus.burst_start = 1'b0;
      wait_cyc(b + 5);
      check("pulse_before_reset", int'(bus.step_en), 1);
      reset_n = 1'b0;
      #1;
      check("async_rst_step_en", int'(bus.step_en), 0);
      check("async_rst_running", int'(bus.running), 0);
      check("async_rst_burst", int'(bus.burst_active), 0);
      check("async_rst_count", int'(bus.step_count), 0);
      exp_q.delete();
      exp_cnt = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) run_burst(15, 4, 1'b0);
      check("count_at_255", int'(bus.step_count), 255);
      run_burst(1, 4, 1'b0);
      check("wrap_to_zero", int'(bus.step_count), 0);

      repeat (20) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/led_step_sequencer.md
Name: led_step_sequencer

Overview:
- Clocked controller that drives the `enable` input of the 4-LED rotator. The rotator advances one quarter-turn per rising edge of `enable`.
- Produces clean, fixed-width step pulses at a selectable rate.
- Supports continuous run (toggled by a raw push-button) and finite bursts of N steps.
- Sits between the board button/config inputs and the rotator. Also exports status for debug LEDs.

Parameters:
- TICK_DIV, 1200000, clk cycles per base tick (10 Hz at 12 MHz).
- PULSE_LEN, 4, cycles `step_en` is held high; also the minimum low gap after each pulse.
- DEBOUNCE_CYCLES, 120000, cycles `btn_run` must be stable before the debounced level changes.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- btn_run  in  1  raw asynchronous push-button, active-high; a debounced press toggles continuous run.
- burst_start  in  1  synchronous single-cycle request to start a burst.
- burst_len  in  4  number of steps in a burst; 0 means the request is ignored.
- speed  in  2  interval between steps = (1<<speed) base ticks.
- step_en  out  1  connects to the rotator `enable`.
- running  out  1  high whenever state != IDLE.
- burst_active  out  1  high while a burst is in progress.
- step_count  out  8  total steps issued, wraps 255->0.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; step_en=0, running=0, burst_active=0, step_count=0.
  - Synchroniser, debounce, prescaler and remaining-burst counters all cleared.
  - Asserting reset mid-pulse drops step_en immediately.
- Button path:
  - 2-FF synchroniser, then a debounce counter.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - A debounced rising edge produces a one-cycle `toggle`.
  - Release edges do nothing.
- FSM states: IDLE, WAIT, PULSE, GAP.
- IDLE:
  - step_en=0.
  - On `toggle`: go to WAIT in continuous mode.
  - Else on burst_start with burst_len!=0: load remaining=burst_len, set burst_active, go to WAIT.
  - If `toggle` and burst_start occur in the same cycle, continuous wins and the burst is ignored.
- WAIT:
  - `speed` is sampled on entry.
  - Lasts exactly WAIT_LEN = (1<<speed)*TICK_DIV cycles, then goes to PULSE.
  - Prescaler and interval counters run only in WAIT and restart from 0 on every entry.
- PULSE:
  - step_en=1 for exactly PULSE_LEN cycles, then GAP.
  - step_count increments by 1 on the entry edge.
  - In burst mode, remaining decrements on the entry edge.
- GAP:
  - step_en=0 for exactly PULSE_LEN cycles.
  - Then go to IDLE if a stop is pending, or if in burst mode with remaining==0 (also clear burst_active).
  - Otherwise go to WAIT.
- Stop requests:
  - `toggle` while not IDLE (continuous or burst) sets `stop_pending`.
  - From WAIT: go to IDLE at the next edge; no pulse is issued.
  - From PULSE/GAP: the request is deferred until GAP completes, so a pulse is never truncated and low time is never shortened.
  - stop_pending is cleared on entering IDLE.
- Other rules:
  - burst_start while not IDLE is ignored.
  - `speed` changes mid-WAIT take effect at the next WAIT entry.
- Timing:
  - Start event at cycle T: state=WAIT at T+1, and step_en rises at T+1+WAIT_LEN.
  - Continuous rising-edge period = WAIT_LEN + 2*PULSE_LEN.
  - A burst of N steps issues exactly N pulses, then IDLE.
  - step_en is registered and glitch-free.

Test Plan:
(Parameters: TICK_DIV=4, PULSE_LEN=2, DEBOUNCE_CYCLES=8.)
- Reset: release reset_n with no inputs, run 100 cycles -> step_en=0, running=0, step_count=0 throughout.
- Debounce: btn_run bounces 0/1 every 3 cycles for 30 cycles -> no toggle, state stays IDLE. Then hold btn_run high 12 cycles -> running=1, first step_en rise 4 cycles after WAIT entry, high 2 cycles.
- Continuous, speed=1:
  - step_en rises every 12 cycles.
  - After 5 pulses step_count=5.
  - A second press lands during PULSE -> the current pulse completes at full width, GAP runs 2 cycles, then running=0.
- Burst: burst_len=3, speed=0, one-cycle burst_start -> exactly 3 step_en pulses 8 cycles apart, then burst_active=0, running=0, step_count +=3. A burst_start issued mid-burst is ignored.
- Simultaneous/ignored requests: toggle and burst_start in the same IDLE cycle -> continuous run, burst_active=0. burst_len=0 with burst_start -> stays IDLE.
- Wrap and async reset:
  - Issue 256 steps -> step_count returns to 0.
  - Assert reset_n low while step_en=1 -> step_en=0 with no clock edge needed; all outputs reset.
